// File: rtl/keypad_emulator.sv
// keypad_emulator
//   Far end of a 4x3 keypad scan interface. Key codes arrive over a
//   valid/ready handshake into a small FIFO; each code is then "pressed"
//   for PRESS_CYCLES cycles and released for a gap before the next one.
//   While a key is pressed, the sense line of its column follows the scan
//   line of its row, combinationally, just like a physical switch.
//
//   Optional feature macro: KEYPAD_EMU_SCANCHK_EN
//     defined   : scan_err latches high if {A,B,C,D} is ever not one-hot
//                 after reset release (cleared only by reset)
//     undefined : checker absent, scan_err tied low
//
// Ports
//   sys_clk, sys_rst_n : clock, async active-low reset
//   A,B,C,D            : scan lines (rows 1-3, 4-6, 7-9, a-c)
//   E,F,G              : sense lines (columns 1/4/7/a, 2/5/8/b, 3/6/9/c)
//   key_valid/key_code : key code offer (legal 0x1..0xC)
//   key_ready          : FIFO not full
//   busy               : FSM active or FIFO non-empty
//   cur_code           : key being pressed, 0xF when none
//   code_err           : one-cycle pulse for an accepted illegal code
//   scan_err           : sticky scan-protocol violation
//
// State table
//   S_IDLE  | no key pressed; pops the FIFO head when one is queued
//   S_PRESS | key held pressed; counts PRESS_CYCLES
//   S_GAP   | key released; counts GAP_CYCLES before returning to idle

module keypad_emulator #(
  parameter int PRESS_CYCLES = 8000,
  parameter int GAP_CYCLES   = 8000,
  parameter int DEPTH        = 4
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       A,
  input  logic       B,
  input  logic       C,
  input  logic       D,
  output logic       E,
  output logic       F,
  output logic       G,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic       key_ready,
  output logic       busy,
  output logic [3:0] cur_code,
  output logic       code_err,
  output logic       scan_err
);

  localparam int MAXC = (PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int AW   = $clog2(DEPTH);

  localparam logic [CW-1:0] PRESS_TC = CW'(PRESS_CYCLES - 1);
  localparam logic [CW-1:0] GAP_TC   = CW'(GAP_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PRESS = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] NO_KEY = 4'hF;

  logic [3:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_cur;
  logic          r_code_err;

  logic w_full;
  logic w_empty;
  logic w_accept;
  logic w_legal;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == FULL_CNT);
  assign w_empty  = (r_count == '0);
  assign w_accept = key_valid && !w_full;
  assign w_legal  = (key_code >= 4'h1) && (key_code <= 4'hC);
  // Illegal codes complete the handshake but never reach the FIFO.
  assign w_push   = w_accept && w_legal;
  assign w_pop    = (r_state == S_IDLE) && !w_empty;

  assign key_ready = !w_full;
  assign busy      = (r_state != S_IDLE) || !w_empty;
  assign cur_code  = r_cur;
  assign code_err  = r_code_err;

  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= key_code;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_code_err <= 1'b0;
    end else begin
      r_code_err <= w_accept && !w_legal;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_cur   <= NO_KEY;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_cur   <= r_mem[r_rd_ptr];
            r_cnt   <= '0;
            r_state <= S_PRESS;
          end
        end
        S_PRESS: begin
          if (r_cnt == PRESS_TC) begin
            r_cur   <= NO_KEY;
            r_cnt   <= '0;
            r_state <= S_GAP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_GAP: begin
          if (r_cnt == GAP_TC) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_cur   <= NO_KEY;
          r_cnt   <= '0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // Switch matrix: row = (code-1)/3 selects the scan line, column =
  // (code-1)%3 selects the sense line. Purely combinational.
  always_comb begin
    E = 1'b0;
    F = 1'b0;
    G = 1'b0;
    case (r_cur)
      4'h1: E = A;
      4'h2: F = A;
      4'h3: G = A;
      4'h4: E = B;
      4'h5: F = B;
      4'h6: G = B;
      4'h7: E = C;
      4'h8: F = C;
      4'h9: G = C;
      4'hA: E = D;
      4'hB: F = D;
      4'hC: G = D;
      default: ;
    endcase
  end

`ifdef KEYPAD_EMU_SCANCHK_EN
  logic [3:0] w_scan;
  logic       w_onehot;
  logic       r_scan_err;

  assign w_scan   = {A, B, C, D};
  assign w_onehot = (w_scan != 4'd0) && ((w_scan & (w_scan - 4'd1)) == 4'd0);

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)     r_scan_err <= 1'b0;
    else if (!w_onehot) r_scan_err <= 1'b1;
  end

  assign scan_err = r_scan_err;
`else
  assign scan_err = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

  localparam int PRESS = 12;
  localparam int GAP   = 6;

`ifdef KEYPAD_EMU_SCANCHK_EN
  localparam logic SCANCHK = 1'b1;
`else
  localparam logic SCANCHK = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       A, B, C, D;
  logic       E, F, G;
  logic       key_valid;
  logic [3:0] key_code;
  logic       key_ready;
  logic       busy;
  logic [3:0] cur_code;
  logic       code_err;
  logic       scan_err;

  int n_err    = 0;
  int n_checks = 0;

  keypad_emulator #(.PRESS_CYCLES(PRESS), .GAP_CYCLES(GAP), .DEPTH(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .A         (A),
    .B         (B),
    .C         (C),
    .D         (D),
    .E         (E),
    .F         (F),
    .G         (G),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_ready (key_ready),
    .busy      (busy),
    .cur_code  (cur_code),
    .code_err  (code_err),
    .scan_err  (scan_err)
  );

  always #5 sys_clk = ~sys_clk;

  // Log of every newly pressed key, in order.
  logic [3:0] press_log [$];
  logic [3:0] prev_code = 4'hF;
  always @(negedge sys_clk) begin
    if (cur_code != prev_code && cur_code != 4'hF) press_log.push_back(cur_code);
    prev_code = cur_code;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_scan(input logic [3:0] s);
    {A, B, C, D} = s;
  endtask

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic push(input logic [3:0] c);
    int n = 0;
    key_valid = 1'b1;
    key_code  = c;
    while (!key_ready && n < 100) begin
      @(negedge sys_clk);
      n++;
    end
    check("push_ready", key_ready, 1'b1);
    @(negedge sys_clk);
    key_valid = 1'b0;
  endtask

  task automatic wait_code(input logic [3:0] c);
    int n = 0;
    while (cur_code != c && n < 200) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_code", cur_code, c);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 400) begin
      @(negedge sys_clk);
      n++;
    end
    check("wait_idle", busy, 1'b0);
  endtask

  typedef struct packed {
    logic [3:0] code;
    logic [3:0] scan;   // {A,B,C,D}
    logic [2:0] efg;    // {E,F,G}
  } vec_t;

  vec_t vecs [14];
  logic [3:0] seq [3];
  logic [3:0] fifo_exp [7];

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_code;
    logic       exp_busy;

    vecs[0]  = '{4'h1, 4'b1000, 3'b100};
    vecs[1]  = '{4'h2, 4'b1000, 3'b010};
    vecs[2]  = '{4'h3, 4'b1000, 3'b001};
    vecs[3]  = '{4'h4, 4'b0100, 3'b100};
    vecs[4]  = '{4'h5, 4'b0100, 3'b010};
    vecs[5]  = '{4'h6, 4'b0010, 3'b000};
    vecs[6]  = '{4'h7, 4'b0010, 3'b100};
    vecs[7]  = '{4'h8, 4'b0010, 3'b010};
    vecs[8]  = '{4'h9, 4'b0001, 3'b000};
    vecs[9]  = '{4'hA, 4'b0001, 3'b100};
    vecs[10] = '{4'hB, 4'b0001, 3'b010};
    vecs[11] = '{4'hC, 4'b0001, 3'b001};
    vecs[12] = '{4'h8, 4'b1000, 3'b000};
    vecs[13] = '{4'h6, 4'b0100, 3'b001};

    seq[0] = 4'h1; seq[1] = 4'hC; seq[2] = 4'h9;
    fifo_exp[0] = 4'h2; fifo_exp[1] = 4'h3; fifo_exp[2] = 4'h4; fifo_exp[3] = 4'h6;
    fifo_exp[4] = 4'h7; fifo_exp[5] = 4'h8; fifo_exp[6] = 4'hA;

    sys_rst_n = 1'b0;
    key_valid = 1'b0;
    key_code  = 4'h0;
    set_scan(4'b1000);

    // Reset state
    #12;
    check("rst_ready", key_ready, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_code", cur_code, 4'hF);
    check("rst_efg", {E, F, G}, 3'b000);
    check("rst_code_err", code_err, 1'b0);
    check("rst_scan_err", scan_err, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);

    // Single key 0x5 with rotating scan lines
    key_valid = 1'b1;
    key_code  = 4'h5;
    @(negedge sys_clk);
    key_valid = 1'b0;
    check("k5_code_after_accept", cur_code, 4'hF);
    check("k5_busy_after_accept", busy, 1'b1);
    for (int i = 0; i < PRESS; i++) begin
      @(negedge sys_clk);
      set_scan(4'b1000 >> (i % 4));
      #1;
      check("k5_code", cur_code, 4'h5);
      check("k5_efg", {E, F, G}, {1'b0, B, 1'b0});
    end
    @(negedge sys_clk);
    set_scan(4'b0100);
    #1;
    check("k5_released_code", cur_code, 4'hF);
    check("k5_released_efg", {E, F, G}, 3'b000);
    set_scan(4'b1000);
    wait_idle();

    // Matrix decode table
    for (int v = 0; v < 14; v++) begin
      push(vecs[v].code);
      wait_code(vecs[v].code);
      set_scan(vecs[v].scan);
      #1;
      check("matrix_efg", {E, F, G}, vecs[v].efg);
      set_scan(4'b1000);
      wait_idle();
    end

    // Back-to-back 0x1, 0xC, 0x9 with key_valid held
    key_valid = 1'b1;
    key_code  = 4'h1;
    for (int t = 1; t <= 60; t++) begin
      @(negedge sys_clk);
      exp_code = 4'hF;
      for (int j = 0; j < 3; j++)
        if (t >= 2 + (PRESS + GAP + 1) * j && t <= 1 + PRESS + (PRESS + GAP + 1) * j)
          exp_code = seq[j];
      exp_busy = (t <= 2 + 2 * (PRESS + GAP + 1) + PRESS + GAP - 1);
      check("b2b_code", cur_code, exp_code);
      check("b2b_busy", busy, exp_busy);
      if (t <= 2) check("b2b_ready", key_ready, 1'b1);
      if (t == 1) key_code = 4'hC;
      if (t == 2) key_code = 4'h9;
      if (t == 3) key_valid = 1'b0;
    end
    wait_idle();

    // FIFO fill while pressing: 6 codes behind an active key
    press_log.delete();
    push(4'h2);
    wait_code(4'h2);
    push(4'h3);
    push(4'h4);
    push(4'h6);
    check("fifo_ready_before_full", key_ready, 1'b1);
    push(4'h7);
    check("fifo_full_ready", key_ready, 1'b0);
    check("fifo_full_still_pressing", cur_code, 4'h2);
    push(4'h8);
    push(4'hA);
    wait_idle();
    check("fifo_log_size", press_log.size(), 7);
    for (int k = 0; k < 7; k++)
      if (k < press_log.size()) check("fifo_order", press_log[k], fifo_exp[k]);

    // Illegal codes
    push(4'h0);
    check("ill0_err", code_err, 1'b1);
    check("ill0_busy", busy, 1'b0);
    @(negedge sys_clk);
    check("ill0_err_clear", code_err, 1'b0);
    push(4'hE);
    check("illE_err", code_err, 1'b1);
    check("illE_busy", busy, 1'b0);
    check("illE_ready", key_ready, 1'b1);
    @(negedge sys_clk);
    check("illE_err_clear", code_err, 1'b0);
    check("ill_busy_after", busy, 1'b0);

    // Reset in the middle of a press of 0x3 with A=1
    set_scan(4'b1000);
    push(4'h3);
    wait_code(4'h3);
    repeat (5) @(negedge sys_clk);
    check("mid_g_before", G, 1'b1);
    #2 sys_rst_n = 1'b0;
    #1;
    check("mid_g_reset", G, 1'b0);
    check("mid_code_reset", cur_code, 4'hF);
    check("mid_busy_reset", busy, 1'b0);
    check("mid_ready_reset", key_ready, 1'b1);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(negedge sys_clk);
    check("mid_code_after", cur_code, 4'hF);
    check("mid_busy_after", busy, 1'b0);
    check("mid_ready_after", key_ready, 1'b1);
    check("mid_efg_after", {E, F, G}, 3'b000);

    // Scan protocol violation
    check("scan_err_clean", scan_err, 1'b0);
    set_scan(4'b1100);
    @(negedge sys_clk);
    set_scan(4'b1000);
    check("scan_err_set", scan_err, SCANCHK);
    repeat (3) @(negedge sys_clk);
    check("scan_err_sticky", scan_err, SCANCHK);
    #2 sys_rst_n = 1'b0;
    #1;
    check("scan_err_reset", scan_err, 1'b0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    repeat (2) @(negedge sys_clk);
    check("scan_err_after_reset", scan_err, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
